// File: rtl/muldiv_wb_arbiter.sv
// Writeback arbiter for the mult functional unit: merges the non-stallable multiplier
// and the iterative divider onto one registered writeback port, with a divider result FIFO.
module muldiv_wb_arbiter #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned TRANS_ID_BITS  = 3,
    parameter int unsigned DIV_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     mul_valid_i,
    input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
    input  logic [XLEN-1:0]          mul_result_i,
    input  logic                     div_valid_i,
    output logic                     div_ready_o,
    input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
    input  logic [XLEN-1:0]          div_result_i,
    output logic                     mul_stall_o,
    output logic                     result_valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [XLEN-1:0]          result_o
);

    localparam int unsigned PTR_W = (DIV_FIFO_DEPTH > 1) ? $clog2(DIV_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DIV_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ONE   = STV_W'(1);

    logic [TRANS_ID_BITS-1:0] r_fifo_id   [DIV_FIFO_DEPTH];
    logic [XLEN-1:0]          r_fifo_data [DIV_FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [STV_W-1:0]         r_starve;
    logic                     r_stall;
    logic                     r_valid;
    logic [TRANS_ID_BITS-1:0] r_id;
    logic [XLEN-1:0]          r_result;

    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_div_hs;
    logic                     w_load;
    logic                     w_pop;
    logic                     w_bypass;
    logic                     w_push;
    logic [TRANS_ID_BITS-1:0] w_next_id;
    logic [XLEN-1:0]          w_next_result;
    logic [CNT_W-1:0]         w_next_count;
    logic                     w_starve_inc;
    logic [STV_W-1:0]         w_starve_plus;
    logic                     w_starve_hit;

    assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
    assign w_fifo_full  = (r_count == FULL_CNT);

    // Ready depends only on occupancy so the divider never sees a combinational path from mul_valid_i.
    assign div_ready_o  = ~w_fifo_full;
    assign w_div_hs     = div_valid_i & ~w_fifo_full;

    // Output source selection: multiplier first, then queued divider results, then divider bypass.
    always_comb begin
        w_load        = 1'b0;
        w_pop         = 1'b0;
        w_bypass      = 1'b0;
        w_next_id     = r_id;
        w_next_result = r_result;
        if (mul_valid_i) begin
            w_load        = 1'b1;
            w_next_id     = mul_trans_id_i;
            w_next_result = mul_result_i;
        end else if (!w_fifo_empty) begin
            w_load        = 1'b1;
            w_pop         = 1'b1;
            w_next_id     = r_fifo_id[r_rd_ptr];
            w_next_result = r_fifo_data[r_rd_ptr];
        end else if (w_div_hs) begin
            w_load        = 1'b1;
            w_bypass      = 1'b1;
            w_next_id     = div_trans_id_i;
            w_next_result = div_result_i;
        end else begin
            w_load        = 1'b0;
        end
    end

    assign w_push = w_div_hs & ~w_bypass;

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + CNT_ONE;
            2'b01:   w_next_count = r_count - CNT_ONE;
            default: w_next_count = r_count;
        endcase
    end

    // A multiplier win counts as starving only while divider results are waiting.
    assign w_starve_inc  = mul_valid_i & ~w_fifo_empty;
    assign w_starve_plus = r_starve + STV_ONE;
    assign w_starve_hit  = w_starve_inc & (w_starve_plus == STV_LIMIT);

    // Registered writeback port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid  <= 1'b0;
            r_id     <= {TRANS_ID_BITS{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else if (flush_i) begin
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_id     <= w_next_id;
                r_result <= w_next_result;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_next_count;
        end
    end

    // FIFO storage; a flush only needs the pointers cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DIV_FIFO_DEPTH; i++) begin
                r_fifo_id[i]   <= {TRANS_ID_BITS{1'b0}};
                r_fifo_data[i] <= {XLEN{1'b0}};
            end
        end else if (w_push && !flush_i) begin
            r_fifo_id[r_wr_ptr]   <= div_trans_id_i;
            r_fifo_data[r_wr_ptr] <= div_result_i;
        end
    end

    // Starvation guard: one-cycle issue stall once the multiplier has won too often in a row.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve <= {STV_W{1'b0}};
            r_stall  <= 1'b0;
        end else if (flush_i) begin
            r_starve <= {STV_W{1'b0}};
            r_stall  <= 1'b0;
        end else if (w_starve_hit) begin
            r_starve <= {STV_W{1'b0}};
            r_stall  <= 1'b1;
        end else if (w_starve_inc) begin
            r_starve <= w_starve_plus;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= {STV_W{1'b0}};
            r_stall  <= 1'b0;
        end
    end

    assign mul_stall_o    = r_stall;
    assign result_valid_o = r_valid;
    assign trans_id_o     = r_id;
    assign result_o       = r_result;

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Bench for muldiv_wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_muldiv_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int TIDW  = 3;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b1;
    logic            flush_i = 1'b0;
    logic            mul_valid_i = 1'b0;
    logic [TIDW-1:0] mul_trans_id_i = '0;
    logic [XLEN-1:0] mul_result_i = '0;
    logic            div_valid_i = 1'b0;
    logic            div_ready_o;
    logic [TIDW-1:0] div_trans_id_i = '0;
    logic [XLEN-1:0] div_result_i = '0;
    logic            mul_stall_o;
    logic            result_valid_o;
    logic [TIDW-1:0] trans_id_o;
    logic [XLEN-1:0] result_o;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_wb_arbiter #(
        .XLEN(XLEN), .TRANS_ID_BITS(TIDW), .DIV_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .mul_valid_i(mul_valid_i), .mul_trans_id_i(mul_trans_id_i), .mul_result_i(mul_result_i),
        .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
        .div_trans_id_i(div_trans_id_i), .div_result_i(div_result_i),
        .mul_stall_o(mul_stall_o), .result_valid_o(result_valid_o),
        .trans_id_o(trans_id_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending divider results and a win streak counter.
    typedef struct packed { logic [TIDW-1:0] id; logic [XLEN-1:0] res; } ent_t;
    ent_t            q[$];
    ent_t            head;
    logic            exp_valid = 1'b0;
    logic [TIDW-1:0] exp_id = '0;
    logic [XLEN-1:0] exp_res = '0;
    logic            exp_stall = 1'b0;
    int              streak = 0;
    int              occ;
    bit              hs, taken;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q.delete();
            exp_valid = 1'b0; exp_id = '0; exp_res = '0; exp_stall = 1'b0; streak = 0;
        end else if (flush_i) begin
            q.delete();
            exp_valid = 1'b0; exp_stall = 1'b0; streak = 0;
        end else begin
            occ   = q.size();
            hs    = div_valid_i && (occ < DEPTH);
            taken = 1'b0;
            if (mul_valid_i) begin
                exp_valid = 1'b1; exp_id = mul_trans_id_i; exp_res = mul_result_i;
            end else if (occ > 0) begin
                head = q.pop_front();
                exp_valid = 1'b1; exp_id = head.id; exp_res = head.res;
            end else if (hs) begin
                exp_valid = 1'b1; exp_id = div_trans_id_i; exp_res = div_result_i;
                taken = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            if (hs && !taken) q.push_back('{id: div_trans_id_i, res: div_result_i});
            if (mul_valid_i && occ > 0) begin
                streak++;
                if (streak == LIMIT) begin
                    exp_stall = 1'b1; streak = 0;
                end else begin
                    exp_stall = 1'b0;
                end
            end else begin
                streak = 0; exp_stall = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        chk("m_valid", {63'd0, result_valid_o}, {63'd0, exp_valid});
        chk("m_id",    {61'd0, trans_id_o},     {61'd0, exp_id});
        chk("m_res",   result_o,                exp_res);
        chk("m_stall", {63'd0, mul_stall_o},    {63'd0, exp_stall});
        chk("m_ready", {63'd0, div_ready_o},    {63'd0, (q.size() < DEPTH)});
    end

    task automatic step(input logic mv, input logic [TIDW-1:0] mid, input logic [XLEN-1:0] mr,
                        input logic dv, input logic [TIDW-1:0] did, input logic [XLEN-1:0] dr,
                        input logic fl);
        mul_valid_i = mv; mul_trans_id_i = mid; mul_result_i = mr;
        div_valid_i = dv; div_trans_id_i = did; div_result_i = dr;
        flush_i = fl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0);
    endtask

    task automatic mul_only(input logic [TIDW-1:0] id, input logic [XLEN-1:0] r);
        step(1'b1, id, r, 1'b0, 3'd0, 64'd0, 1'b0);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("rst_id",    {61'd0, trans_id_o},     64'd0);
        chk("rst_res",   result_o,                64'd0);
        chk("rst_stall", {63'd0, mul_stall_o},    64'd0);
        chk("rst_ready", {63'd0, div_ready_o},    64'd1);
        rst_ni = 1'b1;

        // Multiplier: one-cycle latency.
        mul_only(3'd3, 64'h1234);
        chk("mul_valid", {63'd0, result_valid_o}, 64'd1);
        chk("mul_id",    {61'd0, trans_id_o},     64'd3);
        chk("mul_res",   result_o,                64'h1234);
        chk("mul_ready", {63'd0, div_ready_o},    64'd1);
        idle();
        chk("idle_valid", {63'd0, result_valid_o}, 64'd0);
        chk("idle_hold",  result_o,                64'h1234);

        // Divider bypass with empty FIFO.
        step(1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 64'hDEAD, 1'b0);
        chk("byp_valid", {63'd0, result_valid_o}, 64'd1);
        chk("byp_id",    {61'd0, trans_id_o},     64'd5);
        chk("byp_res",   result_o,                64'hDEAD);
        chk("byp_ready", {63'd0, div_ready_o},    64'd1);
        idle();

        // Collision: multiplier first, divider one cycle later.
        step(1'b1, 3'd1, 64'h11, 1'b1, 3'd2, 64'h22, 1'b0);
        chk("col_id1", {61'd0, trans_id_o}, 64'd1);
        idle();
        chk("col_id2",  {61'd0, trans_id_o}, 64'd2);
        chk("col_res2", result_o,            64'h22);
        idle();
        chk("col_done", {63'd0, result_valid_o}, 64'd0);

        // Fill: FIFO takes 4 and 5, divider holds 6 while full.
        step(1'b1, 3'd0, 64'hA0, 1'b1, 3'd4, 64'h44, 1'b0);
        step(1'b1, 3'd1, 64'hA1, 1'b1, 3'd5, 64'h55, 1'b0);
        chk("fill_full1", {63'd0, div_ready_o}, 64'd0);
        step(1'b1, 3'd2, 64'hA2, 1'b1, 3'd6, 64'h66, 1'b0);
        chk("fill_full2", {63'd0, div_ready_o}, 64'd0);
        chk("fill_mul",   {61'd0, trans_id_o},  64'd2);
        step(1'b0, 3'd0, 64'd0, 1'b1, 3'd6, 64'h66, 1'b0);
        chk("drain_4", {61'd0, trans_id_o}, 64'd4);
        step(1'b0, 3'd0, 64'd0, 1'b1, 3'd6, 64'h66, 1'b0);
        chk("drain_5", {61'd0, trans_id_o}, 64'd5);
        idle();
        chk("drain_6",   {61'd0, trans_id_o}, 64'd6);
        chk("drain_6r",  result_o,            64'h66);
        idle();
        chk("drain_end", {63'd0, result_valid_o}, 64'd0);

        // Starvation: one queued entry, continuous multiplies.
        step(1'b1, 3'd7, 64'h70, 1'b1, 3'd3, 64'h33, 1'b0);
        mul_only(3'd1, 64'h71);
        chk("stv_s1", {63'd0, mul_stall_o}, 64'd0);
        mul_only(3'd2, 64'h72);
        mul_only(3'd4, 64'h73);
        chk("stv_s3", {63'd0, mul_stall_o}, 64'd0);
        mul_only(3'd5, 64'h74);
        chk("stv_pulse", {63'd0, mul_stall_o}, 64'd1);
        chk("stv_mulid", {61'd0, trans_id_o},  64'd5);
        idle();
        chk("stv_clear", {63'd0, mul_stall_o},    64'd0);
        chk("stv_valid", {63'd0, result_valid_o}, 64'd1);
        chk("stv_id",    {61'd0, trans_id_o},     64'd3);
        chk("stv_res",   result_o,                64'h33);
        idle();

        // Flush with two queued entries and a valid output.
        step(1'b1, 3'd1, 64'hB1, 1'b1, 3'd1, 64'hC1, 1'b0);
        step(1'b1, 3'd2, 64'hB2, 1'b1, 3'd2, 64'hC2, 1'b0);
        chk("fl_full",  {63'd0, div_ready_o},    64'd0);
        chk("fl_valid", {63'd0, result_valid_o}, 64'd1);
        step(1'b1, 3'd3, 64'hB3, 1'b1, 3'd3, 64'hC3, 1'b1);
        chk("fl_nvalid", {63'd0, result_valid_o}, 64'd0);
        chk("fl_ready",  {63'd0, div_ready_o},    64'd1);
        chk("fl_stall",  {63'd0, mul_stall_o},    64'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("fl_after", {63'd0, result_valid_o}, 64'd0);
        end

        // Asynchronous reset with a queued entry.
        step(1'b1, 3'd4, 64'hD4, 1'b1, 3'd5, 64'hD5, 1'b0);
        mul_valid_i = 1'b0; div_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_valid", {63'd0, result_valid_o}, 64'd0);
        chk("ar_id",    {61'd0, trans_id_o},     64'd0);
        chk("ar_res",   result_o,                64'd0);
        chk("ar_ready", {63'd0, div_ready_o},    64'd1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        idle();
        chk("ar_lost", {63'd0, result_valid_o}, 64'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
